// File: rtl/hkg_pkg.sv
// Shared types, constants and helpers for the logarithmic key generator stages.
package hkg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_S = 2'd1,
    MIX    = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int unsigned CNT_W        = 4;
  localparam int unsigned ROT_A        = 5;
  localparam int unsigned ROT_B        = 11;
  localparam logic [31:0] DEFAULT_SEED = 32'h9E37_79B9;

  // Rotate left within the low w bits of a 64-bit carrier (w in 16..64).
  function automatic logic [63:0] rotl(input logic [63:0] x,
                                       input int unsigned amt,
                                       input int unsigned w);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = x & mask;
    return ((v << amt) | (v >> (w - amt))) & mask;
  endfunction

endpackage

// File: rtl/hkg_mix_round.sv
// One add-rotate-xor mixing round; purely combinational.
module hkg_mix_round
  import hkg_pkg::*;
#(
  parameter int unsigned KEY_W = 32,
  parameter logic [31:0] SEED  = DEFAULT_SEED
) (
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  input  logic [CNT_W-1:0] cnt,
  output logic [KEY_W-1:0] a_nxt,
  output logic [KEY_W-1:0] b_nxt
);

  // SEED is truncated or zero-extended to the key width.
  localparam logic [KEY_W-1:0] SEED_K = KEY_W'(SEED);

  logic [KEY_W-1:0] b_rot_a;
  logic [KEY_W-1:0] b_rot_b;

  assign b_rot_a = KEY_W'(rotl(64'(b), ROT_A, KEY_W));
  assign b_rot_b = KEY_W'(rotl(64'(b), ROT_B, KEY_W));

  assign a_nxt = (a + b_rot_a) ^ (SEED_K + KEY_W'(cnt));
  assign b_nxt = b_rot_b ^ a;

endmodule

// File: rtl/hkg_key_combiner.sv
// Pairs r/s log keys and mixes them into one combined key.
// Optional HKG_ZERO_REJECT_EN: consume-and-drop zero keys with a zero_err pulse.
module hkg_key_combiner
  import hkg_pkg::*;
#(
  parameter int unsigned KEY_W  = 32,
  parameter int unsigned ROUNDS = 4,
  parameter logic [31:0] SEED   = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_key,
  output logic             seq_err,
  output logic             zero_err
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] a_q, a_d, b_q, b_d;
  logic [KEY_W-1:0] a_mix, b_mix;
  logic [KEY_W-1:0] out_key_q, out_key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             seq_err_q, seq_err_d;
  logic             zero_err_q, zero_err_d;
  logic             in_fire, out_fire, key_zero;

  hkg_mix_round #(.KEY_W(KEY_W), .SEED(SEED)) u_round (
    .a     (a_q),
    .b     (b_q),
    .cnt   (cnt_q),
    .a_nxt (a_mix),
    .b_nxt (b_mix)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

`ifdef HKG_ZERO_REJECT_EN
  assign key_zero = (in_key == '0);
`else
  assign key_zero = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    out_key_d   = out_key_q;
    out_valid_d = out_valid_q;
    seq_err_d   = 1'b0;
    zero_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (key_zero)     zero_err_d = 1'b1;
          else if (!in_sel) begin
            a_d     = in_key;
            state_d = WAIT_S;
          end else          seq_err_d  = 1'b1;
        end
      end
      WAIT_S: begin
        if (in_fire) begin
          if (key_zero) zero_err_d = 1'b1;
          else if (in_sel) begin
            b_d     = in_key;
            cnt_d   = '0;
            state_d = MIX;
          end else begin
            a_d       = in_key;
            seq_err_d = 1'b1;
          end
        end
      end
      MIX: begin
        a_d   = a_mix;
        b_d   = b_mix;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_RND) begin
          out_key_d   = a_mix ^ b_mix;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered decode of the next state keeps in_ready free of input paths.
    in_ready_d = (state_d == IDLE) || (state_d == WAIT_S);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      out_key_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      zero_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      out_key_q   <= out_key_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      seq_err_q   <= seq_err_d;
      zero_err_q  <= zero_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_key   = out_key_q;
  assign seq_err   = seq_err_q;
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_hkg_key_combiner.sv
// Directed self-checking bench for hkg_key_combiner (ROUNDS=4 main, ROUNDS=1 side).
module tb_hkg_key_combiner;

  localparam int unsigned KEY_W = 32;
  localparam logic [31:0] SEED  = 32'h9E37_79B9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, in_sel, out_valid, out_ready, seq_err, zero_err;
  logic [KEY_W-1:0] in_key, out_key;
  logic             in_valid_1, in_ready_1, in_sel_1, out_valid_1, out_ready_1, seq_err_1, zero_err_1;
  logic [KEY_W-1:0] in_key_1, out_key_1;

  hkg_key_combiner #(.KEY_W(KEY_W), .ROUNDS(4), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
    .seq_err(seq_err), .zero_err(zero_err)
  );

  hkg_key_combiner #(.KEY_W(KEY_W), .ROUNDS(1), .SEED(SEED)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1), .in_key(in_key_1),
    .in_sel(in_sel_1), .out_valid(out_valid_1), .out_ready(out_ready_1), .out_key(out_key_1),
    .seq_err(seq_err_1), .zero_err(zero_err_1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] model(input logic [31:0] r, input logic [31:0] s, input int rounds);
    logic [31:0] a, b, na;
    a = r;
    b = s;
    for (int i = 0; i < rounds; i++) begin
      na = (a + rol(b, 5)) ^ (SEED + 32'(i));
      b  = rol(b, 11) ^ a;
      a  = na;
    end
    return a ^ b;
  endfunction

  // Called #1 after an edge; returns #1 after the edge that accepted the key.
  task automatic send(input logic sel, input logic [31:0] key);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_key   = key;
    for (int i = 0; i < 50 && !done; i++) begin
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check(tag, got, 1);
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held, s1;
    bit          stable, ready_low, no_out;

    in_valid = 0; in_sel = 0; in_key = '0; out_ready = 0;
    in_valid_1 = 0; in_sel_1 = 0; in_key_1 = '0; out_ready_1 = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_key", out_key, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_zero_err", zero_err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic pairing on the single-round instance.
`ifdef HKG_ZERO_REJECT_EN
    s1 = 32'h1;
`else
    s1 = 32'h0;
`endif
    in_valid_1 = 1; in_sel_1 = 0; in_key_1 = 32'h1;
    @(posedge clk);
    #1;
    in_sel_1 = 1; in_key_1 = s1;
    @(posedge clk);
    #1;
    in_valid_1 = 0;
    check("r1_valid_early", out_valid_1, 0);
    @(posedge clk);
    #1;
    check("r1_valid", out_valid_1, 1);
`ifdef HKG_ZERO_REJECT_EN
    check("r1_key", out_key_1, model(32'h1, s1, 1));
`else
    check("r1_key", out_key_1, 32'h9E37_79B9);
`endif
    out_ready_1 = 1;
    @(posedge clk);
    #1;
    out_ready_1 = 0;
    check("r1_taken", out_valid_1, 0);

    // Default latency: out_valid exactly 4 edges after s acceptance.
    send(0, 32'h1234_5678);
    send(1, 32'hCAFE_F00D);
    check("lat_e0", out_valid, 0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("lat_early", out_valid, 0);
    end
    @(posedge clk);
    #1;
    check("lat_valid", out_valid, 1);
    check("lat_key", out_key, model(32'h1234_5678, 32'hCAFE_F00D, 4));
    take_output();
    check("lat_taken", out_valid, 0);
    check("lat_ready", in_ready, 1);

    // Sequence errors.
    send(1, 32'h11);
    check("seq_s_first", seq_err, 1);
    @(posedge clk);
    #1;
    check("seq_pulse_end", seq_err, 0);
    check("seq_no_out", out_valid, 0);
    send(0, 32'd5);
    check("seq_r5", seq_err, 0);
    send(0, 32'd7);
    check("seq_r7", seq_err, 1);
    send(1, 32'd9);
    check("seq_s9", seq_err, 0);
    wait_valid("seq_valid");
    check("seq_key", out_key, model(32'd7, 32'd9, 4));

    // Back-pressure, with an input offered that must be ignored.
    held = out_key;
    stable = 1; ready_low = 1;
    in_valid = 1; in_sel = 0; in_key = 32'd123;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_key !== held || out_valid !== 1'b1) stable = 0;
      if (in_ready !== 1'b0) ready_low = 0;
    end
    in_valid = 0;
    check("bp_stable", stable, 1);
    check("bp_in_ready_low", ready_low, 1);
    take_output();
    check("bp_taken", out_valid, 0);
    check("bp_ready", in_ready, 1);
    send(1, 32'h55);
    check("bp_ignored_input", seq_err, 1);

    // Reset during MIX round 2.
    send(0, 32'hA5A5_0001);
    send(1, 32'h0F0F_1234);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_key", out_key, 0);
    check("mrst_seq_err", seq_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    no_out = 1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) no_out = 0;
    end
    check("mrst_no_output", no_out, 1);
    send(0, 32'hDEAD_BEEF);
    send(1, 32'h0BAD_F00D);
    wait_valid("mrst_valid");
    check("mrst_key", out_key, model(32'hDEAD_BEEF, 32'h0BAD_F00D, 4));
    take_output();

    // Zero key handling.
    send(0, 32'h0);
`ifdef HKG_ZERO_REJECT_EN
    check("zero_err_pulse", zero_err, 1);
    check("zero_no_seq", seq_err, 0);
    @(posedge clk);
    #1;
    check("zero_err_end", zero_err, 0);
    send(0, 32'd3);
    check("zero_still_idle", seq_err, 0);
    send(1, 32'd4);
    wait_valid("zero_valid");
    check("zero_key", out_key, model(32'd3, 32'd4, 4));
`else
    check("zero_err_off", zero_err, 0);
    send(1, 32'd4);
    check("zero_accepted", seq_err, 0);
    wait_valid("zero_valid");
    check("zero_key", out_key, model(32'd0, 32'd4, 4));
`endif
    take_output();
    check("final_idle", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hkg_key_combiner.md
# hkg_key_combiner

Downstream stage of the logarithmic key generator. Collects the `r` and `s` logarithmic keys it produces, one at a time, over a valid/ready stream and pairs them. It then runs a fixed number of add-rotate-xor mixing rounds, one per clock. The result is a single combined heterogeneous key, held on a valid/ready output until it is consumed.

## Interface
Parameters:
- `KEY_W`, 32: key width; legal values 16, 32, 64.
- `ROUNDS`, 4: mixing rounds; legal range 1..15.
- `SEED`, 32'h9E3779B9: round constant base, truncated or zero-extended to `KEY_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input key valid.
- `in_ready` out 1: block can accept a key.
- `in_key` in `KEY_W`: log key value.
- `in_sel` in 1: 0 = key derived from `r`, 1 = key derived from `s`.
- `out_valid` out 1: combined key valid.
- `out_ready` in 1: consumer takes the key.
- `out_key` out `KEY_W`: combined key.
- `seq_err` out 1: one-cycle pulse on an out-of-order input.
- `zero_err` out 1: one-cycle pulse on a rejected zero key; tied 0 when the feature is compiled out.

## Operation
- Input handshake: transfer occurs when `in_valid && in_ready` at a rising edge.
- Output handshake: transfer occurs when `out_valid && out_ready` at a rising edge.
- States: IDLE, WAIT_S, MIX, HOLD.
- IDLE (`in_ready`=1):
  - Accepted `in_sel`=0: latch `a`←`in_key`, go to WAIT_S.
  - Accepted `in_sel`=1: key dropped, `seq_err` pulses, stay in IDLE.
- WAIT_S (`in_ready`=1):
  - Accepted `in_sel`=1: latch `b`←`in_key`, clear round counter, go to MIX.
  - Accepted `in_sel`=0: overwrite `a`, `seq_err` pulses, stay in WAIT_S.
- MIX (`in_ready`=0): one round per cycle, all arithmetic mod 2^`KEY_W`, `rotl` is a rotate left, `cnt` is the round index 0..ROUNDS-1:
  - `a'` = (`a` + rotl(`b`,5)) ^ (`SEED` + `cnt`)
  - `b'` = rotl(`b`,11) ^ `a`, using the old `a`
  - After round `ROUNDS`-1: `out_key`←`a'`^`b'`, `out_valid`←1, go to HOLD.
- HOLD (`in_ready`=0): `out_key` and `out_valid` stay stable until the output transfer. On transfer, `out_valid`←0 and the block returns to IDLE.
- `in_ready` is a registered decode of state. It does not depend combinationally on `in_valid` or `out_ready`.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_key`=0, `seq_err`=0, `zero_err`=0, `a`=`b`=0, `cnt`=0.
- Reset asserted mid-MIX or mid-HOLD: the partial or pending key is discarded and no output is produced.

## Timing
- `s` accepted at edge N: MIX rounds execute at edges N+1..N+`ROUNDS`, and `out_valid`=1 after edge N+`ROUNDS`.
- Throughput: one key per 2+`ROUNDS`+1 cycles minimum when inputs are back-to-back and `out_ready`=1.
- Output back-pressure: holding `out_ready`=0 stalls the block in HOLD indefinitely with no data loss.
- Error pulses: `seq_err` and `zero_err` are registered and high for the single cycle after the offending transfer.
- `in_valid` while `in_ready`=0: ignored; the upstream block must hold its data.

## Configuration
- Macro: `HKG_ZERO_REJECT_EN`.
- Defined: an accepted `in_key`==0 (the generator's "input ≤ 0" code) is consumed but not latched. `zero_err` pulses, and state, `a` and `b` are unchanged. This check takes priority over the sequence check, so `seq_err` does not pulse for a zero key.
- Undefined: zero is processed as an ordinary key and `zero_err` is constant 0.

## Structure
- Shared package `hkg_pkg`:
  - state enum (IDLE, WAIT_S, MIX, HOLD)
  - `rotl` function
  - rotate constants 5 and 11
  - default `SEED`
- Sub-module `hkg_mix_round`: purely combinational; inputs `a`, `b`, `cnt`; outputs `a'`, `b'`. Instantiated once and reused every cycle.

## Test plan
- Basic pairing: `KEY_W`=32, `ROUNDS`=1; send `r`=1, then `s`=0 → `out_key`=32'h9E3779B9, `out_valid` high after the edge following `s` acceptance.
- Default latency: `ROUNDS`=4, random `r`/`s` → `out_key` matches the reference model, `out_valid` exactly 4 edges after `s` acceptance.
- Sequence errors: `s` sent first → `seq_err` pulses once, no output. Then `r`=5, `r`=7, `s`=9 → one `seq_err` pulse, and the output equals the model with `r`=7.
- Back-pressure: hold `out_ready`=0 for 20 cycles → `out_key` stable, `in_ready`=0 throughout. Then raise `out_ready` → one transfer, and `in_ready`=1 on the next cycle.
- Reset mid-MIX: assert `rst_n`=0 during round 2 → all outputs at reset values immediately. After release, a fresh `r`/`s` pair gives the correct key.
- `HKG_ZERO_REJECT_EN` defined: send `r`=0 → `zero_err` pulses and state stays IDLE; then `r`=3, `s`=4 → the model result. Undefined: `r`=0 is accepted normally and `zero_err` stays 0.
